spi_master: RTL



---
 rtl/spi_master_pkg.sv | 28 ++
 rtl/spi_master_if.sv | 35 +++
 rtl/spi_clkdiv.sv | 43 ++++
 rtl/spi_master.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg
// Shared definitions for the mode-0 SPI master slice.
//   - FSM state encodings and the state register width
//   - default WIDTH / DIV values
//   - cnt_w(): width of a counter that runs 0..n-1. It returns $clog2(n),
//     but never less than 1 bit, so DIV=1 still gets a legal vector.
// Optional build macro used by spi_master: SPI_MASTER_LSB_FIRST_EN.
package spi_master_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETUP = 3'd1;
    localparam logic [STATE_W-1:0] ST_HIGH  = 3'd2;
    localparam logic [STATE_W-1:0] ST_LOW   = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD  = 3'd4;
    localparam logic [STATE_W-1:0] ST_GAP   = 3'd5;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 4;

    // Divider counter width is cnt_w(DIV).
    // Bit counter width is cnt_w(WIDTH).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if
// Parallel host-side handshake of the SPI master.
//   start    : request a transfer (host -> master)
//   data_in  : word to transmit (host -> master)
//   data_out : last received word (master -> host)
//   busy     : transfer or inter-word gap in progress (master -> host)
//   done     : one-cycle end-of-transfer pulse (master -> host)
// Modports:
//   master : the requesting side (the host logic or a testbench).
//   slave  : the side that serves the requests (spi_master itself).
interface spi_master_if #(
    parameter int WIDTH = spi_master_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output data_in,
        input  data_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output data_out,
        output busy,
        output done
    );
endinterface

// File: rtl/spi_clkdiv.sv
// spi_clkdiv
// Phase timer for the SPI master. It counts 0..DIV-1 and raises phase_end
// on the last count of each phase, so every non-idle FSM state lasts
// exactly DIV clk cycles.
// Ports:
//   clk       : system clock
//   reset_    : asynchronous active-low reset
//   restart   : hold the counter at zero (driven while the FSM is idle)
//   phase_end : high on the final cycle of the current phase
module spi_clkdiv
    import spi_master_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic reset_,
    input  logic restart,
    output logic phase_end
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Every FSM transition out of a non-idle state happens on phase_end,
    // which is exactly when the counter wraps. The counter therefore
    // restarts on each state change without needing a separate strobe.
    // The only exception is leaving IDLE. While idle, the counter is held
    // at zero, so SETUP also starts from a fresh count.
    assign phase_end = (count == LAST) && !restart;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            count <= '0;
        end else if (restart || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master
// Mode-0 (CPOL=0, CPHA=0) full-duplex SPI master. Each transfer sends one
// WIDTH-bit word on ucMOSI and captures one word from ucMISO. SCLK has a
// half-period of DIV clk cycles.
//
// Phase sequence per transfer:
//   SETUP, then (HIGH, LOW) x (WIDTH-1), then HIGH, HOLD, GAP.
// Each phase lasts DIV cycles.
//
// Parameters:
//   WIDTH : bits per transfer (>=2)
//   DIV   : SCLK half-period in clk cycles (>=1)
//
// Ports:
//   clk    : system clock
//   reset_ : asynchronous active-low reset. Asserting it mid-transfer
//            aborts the transfer with no done pulse.
//   host   : spi_master_if.slave handshake
//            (start, data_in, data_out, busy, done)
//   ucSEL_ : active-low slave select
//   ucSCLK : serial clock, idles low
//   ucMOSI : master-out data
//   ucMISO : master-in data. It is assumed synchronous to the SCLK
//            schedule, so there is no synchroniser.
//
// Build option:
//   SPI_MASTER_LSB_FIRST_EN
//     defined   : LSB-first on the wire in both directions
//     undefined : MSB-first in both directions
module spi_master
    import spi_master_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic      clk,
    input  logic      reset_,
    spi_master_if.slave host,
    output logic      ucSEL_,
    output logic      ucSCLK,
    output logic      ucMOSI,
    input  logic      ucMISO
);

    localparam int            BW       = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic [STATE_W-1:0] state;
    logic [WIDTH-1:0]   shreg;
    logic [BW-1:0]      bit_cnt;
    logic [WIDTH-1:0]   data_out_q;
    logic               busy_q;
    logic               done_q;
    logic               phase_end;

    logic               first_bit;
    logic               next_bit;
    logic [WIDTH-1:0]   shifted;

    spi_clkdiv #(
        .DIV(DIV)
    ) u_clkdiv (
        .clk      (clk),
        .reset_   (reset_),
        .restart  (state == ST_IDLE),
        .phase_end(phase_end)
    );

    // One shift register serves both directions. As a received bit enters
    // at one end, the bit just transmitted drops off the other end. After
    // WIDTH HIGH phases, the register holds the received word.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign first_bit = host.data_in[0];
    assign next_bit  = shreg[1];
    assign shifted   = {ucMISO, shreg[WIDTH-1:1]};
`else
    assign first_bit = host.data_in[WIDTH-1];
    assign next_bit  = shreg[WIDTH-2];
    assign shifted   = {shreg[WIDTH-2:0], ucMISO};
`endif

    assign host.data_out = data_out_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;

    // Transfer FSM. All pin outputs are registered here.
    // - ucMOSI changes only on the edge that ends a HIGH phase, which is
    //   also where SCLK falls. It therefore has a full LOW phase of setup
    //   before the next rising edge.
    // - ucMISO is captured on that same falling-edge tick.
    // - GAP keeps ucSEL_ high for at least DIV cycles before the next word
    //   can start.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ucSEL_     <= 1'b1;
            ucSCLK     <= 1'b0;
            ucMOSI     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host.start) begin
                        shreg   <= host.data_in;
                        bit_cnt <= '0;
                        ucSEL_  <= 1'b0;
                        busy_q  <= 1'b1;
                        ucMOSI  <= first_bit;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        ucSCLK <= 1'b1;
                        state  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        shreg  <= shifted;
                        ucSCLK <= 1'b0;
                        if (bit_cnt != LAST_BIT) begin
                            ucMOSI  <= next_bit;
                            bit_cnt <= bit_cnt + BW'(1);
                            state   <= ST_LOW;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        ucSCLK <= 1'b1;
                        state  <= ST_HIGH;
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        ucSEL_     <= 1'b1;
                        ucMOSI     <= 1'b0;
                        data_out_q <= shreg;
                        done_q     <= 1'b1;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
